bram_chain_activity_monitor: RTL and testbench

BRAM_CHAIN_ACTIVITY_MONITOR -- requirements
Module: bram_chain_activity_monitor

---
 rtl/bram_chain_activity_monitor.sv | 132 +++++++++++++
 tb/tb_bram_chain_activity_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_chain_activity_monitor.sv
// Watches the tail word of a BRAM cascade and measures, per window, how many
// cycles the word changed and how many bits flipped, comparing against an expected rate.
module bram_chain_activity_monitor #(
   parameter int DATAWIDTH = 36,
   parameter int WINDOW    = 100,
   parameter int TOL       = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATAWIDTH-1:0] data_i,
   input  logic                 valid_i,
   input  logic [6:0]           toggle_rate_i,
   input  logic                 start_i,
   input  logic                 continuous_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [6:0]           toggle_count_o,
   output logic [12:0]          bit_toggles_o,
   output logic                 pass_o,
   output logic [15:0]          err_count_o,
   output logic [15:0]          window_count_o
);

   localparam int            CW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
   localparam logic [6:0]    WIN7 = 7'(WINDOW);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [DATAWIDTH-1:0]   prev_q;
   logic [6:0]             exp_q;
   logic [6:0]             tog_acc;
   logic [12:0]            bit_acc;
   logic [CW-1:0]          cyc_cnt;

   logic [12:0]            flips;
   logic                   word_changed;
   logic [6:0]             tog_sum;
   logic [12:0]            bit_sum;
   logic [6:0]             exp_sel;
   logic [6:0]             deviation;
   logic                   within_tol;
   logic                   window_end;

   always_comb begin
      flips = '0;
      for (int i = 0; i < DATAWIDTH; i++) begin
         flips = flips + 13'(data_i[i] ^ prev_q[i]);
      end
   end

   // The final MEASURE sample is folded in combinationally so the result is
   // already registered and visible during the REPORT cycle alongside done_o.
   always_comb begin
      word_changed = valid_i && (data_i != prev_q);
      tog_sum      = tog_acc + 7'(word_changed);
      bit_sum      = valid_i ? (bit_acc + flips) : bit_acc;
      exp_sel      = (toggle_rate_i > WIN7) ? WIN7 : toggle_rate_i;
      deviation    = (tog_sum >= exp_q) ? (tog_sum - exp_q) : (exp_q - tog_sum);
      within_tol   = ({25'd0, deviation} <= 32'(TOL));
      window_end   = (state == MEASURE) && (cyc_cnt == LAST);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = ARM;
         ARM:     if (valid_i) state_nxt = MEASURE;
         MEASURE: if (window_end) state_nxt = REPORT;
         REPORT:  state_nxt = continuous_i ? MEASURE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_o = (state != IDLE) && !rst;
   assign done_o = (state == REPORT) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         prev_q         <= '0;
         exp_q          <= '0;
         tog_acc        <= '0;
         bit_acc        <= '0;
         cyc_cnt        <= '0;
         toggle_count_o <= '0;
         bit_toggles_o  <= '0;
         pass_o         <= 1'b0;
         err_count_o    <= '0;
         window_count_o <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ARM: begin
               if (valid_i) begin
                  prev_q  <= data_i;
                  exp_q   <= exp_sel;
                  tog_acc <= '0;
                  bit_acc <= '0;
                  cyc_cnt <= '0;
               end
            end
            MEASURE: begin
               prev_q  <= data_i;
               tog_acc <= tog_sum;
               bit_acc <= bit_sum;
               cyc_cnt <= cyc_cnt + CW'(1);
               if (window_end) begin
                  toggle_count_o <= tog_sum;
                  bit_toggles_o  <= bit_sum;
                  pass_o         <= within_tol;
                  if (window_count_o != 16'hFFFF)
                     window_count_o <= window_count_o + 16'd1;
                  if (!within_tol && (err_count_o != 16'hFFFF))
                     err_count_o <= err_count_o + 16'd1;
               end
            end
            // prev_q is kept so a back-to-back window compares against the last measured word.
            REPORT: begin
               tog_acc <= '0;
               bit_acc <= '0;
               cyc_cnt <= '0;
               exp_q   <= exp_sel;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_chain_activity_monitor.sv
// Directed bench for bram_chain_activity_monitor: a table of single windows,
// then continuous mode and a mid-window reset sequence.
module tb_bram_chain_activity_monitor;

   localparam logic [35:0] BASE = 36'h5A5AF00F3;

   logic        clk;
   logic        rst;
   logic [35:0] data_i;
   logic        valid_i;
   logic [6:0]  toggle_rate_i;
   logic        start_i;
   logic        continuous_i;
   logic        busy_o;
   logic        done_o;
   logic [6:0]  toggle_count_o;
   logic [12:0] bit_toggles_o;
   logic        pass_o;
   logic [15:0] err_count_o;
   logic [15:0] window_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [6:0]  rate;
      int          ntog;
      logic [6:0]  exp_tc;
      logic [12:0] exp_bits;
      logic        exp_pass;
      logic [15:0] exp_err;
      logic [15:0] exp_win;
   } vec_t;

   vec_t vecs [6];

   bram_chain_activity_monitor #(.DATAWIDTH(36), .WINDOW(100), .TOL(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_i         (data_i),
      .valid_i        (valid_i),
      .toggle_rate_i  (toggle_rate_i),
      .start_i        (start_i),
      .continuous_i   (continuous_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .toggle_count_o (toggle_count_o),
      .bit_toggles_o  (bit_toggles_o),
      .pass_o         (pass_o),
      .err_count_o    (err_count_o),
      .window_count_o (window_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},  32'(busy_o), 0);
      checkOutput({tag, "_done"},  32'(done_o), 0);
      checkOutput({tag, "_tc"},    32'(toggle_count_o), 0);
      checkOutput({tag, "_bits"},  32'(bit_toggles_o), 0);
      checkOutput({tag, "_pass"},  32'(pass_o), 0);
      checkOutput({tag, "_err"},   32'(err_count_o), 0);
      checkOutput({tag, "_win"},   32'(window_count_o), 0);
   endtask

   // One non-continuous window: toggle for the first ntog MEASURE cycles, then hold.
   // start_i stays high and toggle_rate_i is scrambled during MEASURE; neither may matter.
   task automatic applyStimulus(input logic [6:0] rate, input int ntog, output int lat);
      logic [35:0] cur;
      cur     = BASE;
      start_i = 1'b1;
      tick();
      checkOutput("arm_busy", 32'(busy_o), 1);
      toggle_rate_i = rate;
      valid_i       = 1'b1;
      data_i        = cur;
      lat           = 0;
      tick();
      lat++;
      toggle_rate_i = ~rate;
      for (int k = 1; !done_o && lat < 200; k++) begin
         if (k <= ntog) cur = ~cur;
         data_i = cur;
         tick();
         lat++;
      end
      start_i       = 1'b0;
      toggle_rate_i = rate;
   endtask

   initial begin
      int          lat;
      int          t;
      int          ndone;
      int          busy_lows;
      int          done_t [3];
      logic [6:0]  tc_seen [3];
      logic [6:0]  hold_tc;

      vecs[0] = '{7'd100, 100, 7'd100, 13'd3600, 1'b1, 16'd0, 16'd1};
      vecs[1] = '{7'd50,  50,  7'd50,  13'd1800, 1'b1, 16'd0, 16'd2};
      vecs[2] = '{7'd30,  0,   7'd0,   13'd0,    1'b0, 16'd1, 16'd3};
      vecs[3] = '{7'd2,   0,   7'd0,   13'd0,    1'b1, 16'd1, 16'd4};
      vecs[4] = '{7'd127, 100, 7'd100, 13'd3600, 1'b1, 16'd1, 16'd5};
      vecs[5] = '{7'd127, 97,  7'd97,  13'd3492, 1'b0, 16'd2, 16'd6};

      rst           = 1'b1;
      data_i        = '0;
      valid_i       = 1'b0;
      toggle_rate_i = '0;
      start_i       = 1'b0;
      continuous_i  = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();
      checkOutput("idle_busy", 32'(busy_o), 0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].rate, vecs[i].ntog, lat);
         checkOutput($sformatf("v%0d_latency", i), 32'(lat), 101);
         checkOutput($sformatf("v%0d_done", i), 32'(done_o), 1);
         checkOutput($sformatf("v%0d_tc", i), 32'(toggle_count_o), 32'(vecs[i].exp_tc));
         checkOutput($sformatf("v%0d_bits", i), 32'(bit_toggles_o), 32'(vecs[i].exp_bits));
         checkOutput($sformatf("v%0d_pass", i), 32'(pass_o), 32'(vecs[i].exp_pass));
         checkOutput($sformatf("v%0d_err", i), 32'(err_count_o), 32'(vecs[i].exp_err));
         checkOutput($sformatf("v%0d_win", i), 32'(window_count_o), 32'(vecs[i].exp_win));
         hold_tc = toggle_count_o;
         tick();
         checkOutput($sformatf("v%0d_done_pulse", i), 32'(done_o), 0);
         checkOutput($sformatf("v%0d_idle", i), 32'(busy_o), 0);
         checkOutput($sformatf("v%0d_tc_hold", i), 32'(toggle_count_o), 32'(vecs[i].exp_tc));
      end

      // Continuous mode: data flips every cycle including REPORT, whose word is
      // ignored, so windows after the first see 99 changes instead of 100.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      continuous_i = 1'b1;
      start_i      = 1'b1;
      tick();
      start_i       = 1'b0;
      toggle_rate_i = 7'd100;
      valid_i       = 1'b1;
      t             = 0;
      ndone         = 0;
      busy_lows     = 0;
      while (ndone < 3 && t < 400) begin
         data_i = t[0] ? ~BASE : BASE;
         tick();
         t++;
         if (!busy_o) busy_lows++;
         if (done_o) begin
            done_t[ndone]  = t;
            tc_seen[ndone] = toggle_count_o;
            ndone++;
            if (ndone == 3) continuous_i = 1'b0;
         end
      end
      checkOutput("cont_ndone", 32'(ndone), 3);
      if (ndone == 3) begin
         checkOutput("cont_first_done", 32'(done_t[0]), 101);
         checkOutput("cont_spacing1", 32'(done_t[1] - done_t[0]), 101);
         checkOutput("cont_spacing2", 32'(done_t[2] - done_t[1]), 101);
         checkOutput("cont_tc0", 32'(tc_seen[0]), 100);
         checkOutput("cont_tc1", 32'(tc_seen[1]), 99);
         checkOutput("cont_tc2", 32'(tc_seen[2]), 99);
      end
      checkOutput("cont_busy_lows", 32'(busy_lows), 0);
      checkOutput("cont_win", 32'(window_count_o), 3);
      checkOutput("cont_err", 32'(err_count_o), 0);
      checkOutput("cont_pass", 32'(pass_o), 1);
      tick();
      checkOutput("cont_idle", 32'(busy_o), 0);

      // Reset at MEASURE cycle 40 with non-zero counts still standing.
      start_i = 1'b1;
      tick();
      start_i       = 1'b0;
      toggle_rate_i = 7'd100;
      data_i        = BASE;
      tick();
      ndone = 0;
      for (int k = 1; k < 40; k++) begin
         data_i = ~data_i;
         tick();
         if (done_o) ndone++;
      end
      rst    = 1'b1;
      data_i = ~data_i;
      tick();
      checkAllZero("abort");
      tick();
      if (done_o) ndone++;
      checkOutput("abort_no_done", 32'(ndone), 0);
      rst = 1'b0;
      tick();
      applyStimulus(7'd100, 100, lat);
      checkOutput("post_latency", 32'(lat), 101);
      checkOutput("post_tc", 32'(toggle_count_o), 100);
      checkOutput("post_bits", 32'(bit_toggles_o), 3600);
      checkOutput("post_pass", 32'(pass_o), 1);
      checkOutput("post_win", 32'(window_count_o), 1);
      checkOutput("post_err", 32'(err_count_o), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
